// File: rtl/eda_region_ctrl.sv
// Regional-maximum labelling controller: two-pass plateau flood fill over an M x N image,
// driving an external 3x3 window comparator and a 1-bit label write port.
module eda_region_ctrl #(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int ADDR_WIDTH = $clog2(M*N),
  parameter int FIFO_DEPTH = M*N
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  win_req,
  output logic [ADDR_WIDTH-1:0] win_addr,
  input  logic                  win_ack,
  output logic                  new_pixel,
  input  logic                  compare_out,
  input  logic [7:0]            push_positions,
  output logic [7:0]            iterated_idx,
  output logic                  lbl_we,
  output logic [ADDR_WIDTH-1:0] lbl_addr,
  output logic                  lbl_data
);
  localparam int NPIX = M*N;
  localparam int QW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH+1);

  typedef enum logic [3:0] {
    IDLE, SCAN, P1_FETCH, P1_EVAL, P1_PUSH, P2_FETCH, P2_EVAL, P2_PUSH, DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]            pix_st [NPIX];
  logic [ADDR_WIDTH-1:0] q_mem  [FIFO_DEPTH];
  logic [QW-1:0]         q_rd, q_wr;
  logic [CW-1:0]         q_cnt;
  logic [ADDR_WIDTH-1:0] q_head;
  logic [ADDR_WIDTH:0]   ptr;
  logic [ADDR_WIDTH-1:0] seed, cur;
  logic                  plateau_max;
  logic [7:0]            pend;

  logic                  p2;
  logic [1:0]            pass;
  logic [7:0]            nb_ok, elig;
  logic [ADDR_WIDTH-1:0] nb_addr [8];
  logic [2:0]            sel;
  logic                  found;
  int                    r, c, nr, nc;

  logic                  q_push, q_pop, push_ok, st_we, ptr_inc;
  logic [ADDR_WIDTH-1:0] q_push_addr, st_addr;
  logic [1:0]            st_val;

  function automatic logic [QW-1:0] q_nxt(input logic [QW-1:0] p);
    return (p == QW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign p2       = (state == P2_FETCH) || (state == P2_EVAL) || (state == P2_PUSH);
  assign pass     = p2 ? 2'd2 : 2'd1;
  assign q_head   = q_mem[q_rd];
  assign win_addr = q_head;
  assign lbl_addr = q_head;
  assign lbl_data = plateau_max;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign push_ok  = q_push && (q_cnt != CW'(FIFO_DEPTH));

  // Neighbour geometry around the pixel whose window was last acknowledged.
  always_comb begin
    r = int'(cur) / N;
    c = int'(cur) % N;
    nr = 0;
    nc = 0;
    for (int k = 0; k < 8; k++) begin
      nr = r + ((k < 3) ? -1 : (k < 5) ? 0 : 1);
      nc = c + ((k == 0 || k == 3 || k == 5) ? -1 : (k == 1 || k == 6) ? 0 : 1);
      nb_ok[k]        = (nr >= 0) && (nr < M) && (nc >= 0) && (nc < N);
      nb_addr[k]      = nb_ok[k] ? ADDR_WIDTH'(nr*N + nc) : '0;
      iterated_idx[k] = !nb_ok[k] || (pix_st[nb_addr[k]] >= pass);
      elig[k]         = nb_ok[k] && (pix_st[nb_addr[k]] == (p2 ? 2'd1 : 2'd0));
    end
  end

  always_comb begin
    sel = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (pend[k]) sel = 3'(k);
    found = |pend;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    win_req     = 1'b0;
    new_pixel   = 1'b0;
    lbl_we      = 1'b0;
    q_push      = 1'b0;
    q_push_addr = '0;
    q_pop       = 1'b0;
    st_we       = 1'b0;
    st_addr     = '0;
    st_val      = 2'd0;
    ptr_inc     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (ptr >= (ADDR_WIDTH+1)'(NPIX)) state_nxt = DONE;
        else if (pix_st[ptr[ADDR_WIDTH-1:0]] == 2'd2) ptr_inc = 1'b1;
        else begin
          q_push      = 1'b1;
          q_push_addr = ptr[ADDR_WIDTH-1:0];
          st_we       = 1'b1;
          st_addr     = ptr[ADDR_WIDTH-1:0];
          st_val      = 2'd1;
          state_nxt   = P1_FETCH;
        end
      end
      P1_FETCH, P2_FETCH: begin
        win_req = 1'b1;
        if (win_ack) begin
          new_pixel = 1'b1;
          q_pop     = 1'b1;
          lbl_we    = p2;
          state_nxt = p2 ? P2_EVAL : P1_EVAL;
        end
      end
      P1_EVAL: state_nxt = P1_PUSH;
      P2_EVAL: state_nxt = P2_PUSH;
      P1_PUSH, P2_PUSH: begin
        if (found) begin
          q_push      = 1'b1;
          q_push_addr = nb_addr[sel];
          st_we       = 1'b1;
          st_addr     = nb_addr[sel];
          st_val      = pass;
        end else if (q_cnt != '0) begin
          state_nxt = p2 ? P2_FETCH : P1_FETCH;
        end else if (!p2) begin
          // Plateau fully explored: replay it from the seed to write labels.
          q_push      = 1'b1;
          q_push_addr = seed;
          st_we       = 1'b1;
          st_addr     = seed;
          st_val      = 2'd2;
          state_nxt   = P2_FETCH;
        end else begin
          ptr_inc   = 1'b1;
          state_nxt = SCAN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) q_mem[q_wr] <= q_push_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NPIX; i++) pix_st[i] <= 2'd0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      ptr         <= '0;
      seed        <= '0;
      cur         <= '0;
      plateau_max <= 1'b0;
      pend        <= '0;
    end else begin
      if (state == IDLE && start) begin
        for (int i = 0; i < NPIX; i++) pix_st[i] <= 2'd0;
        ptr <= '0;
      end
      if (st_we)   pix_st[st_addr] <= st_val;
      if (push_ok) q_wr <= q_nxt(q_wr);
      if (q_pop)   q_rd <= q_nxt(q_rd);
      q_cnt <= q_cnt + CW'(push_ok) - CW'(q_pop);
      if (ptr_inc) ptr <= ptr + 1'b1;
      if (state == SCAN && q_push) begin
        seed        <= ptr[ADDR_WIDTH-1:0];
        plateau_max <= 1'b1;
      end
      if (q_pop) begin
        cur <= q_head;
        if (!p2 && !compare_out) plateau_max <= 1'b0;
      end
      if (state == P1_EVAL || state == P2_EVAL) pend <= push_positions & elig;
      else if (found && (state == P1_PUSH || state == P2_PUSH)) pend[sel] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_eda_region_ctrl.sv
// Directed bench for eda_region_ctrl on a 4x4 image with a behavioural window comparator.
module tb_eda_region_ctrl;
  localparam int M = 4, N = 4, AW = 4, NP = 16;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic          win_ack = 1'b0, compare_out = 1'b0;
  logic [7:0]    push_positions = '0;
  logic          busy, done, win_req, new_pixel, lbl_we, lbl_data;
  logic [AW-1:0] win_addr, lbl_addr;
  logic [7:0]    iterated_idx;

  eda_region_ctrl #(.M(M), .N(N), .ADDR_WIDTH(AW), .FIFO_DEPTH(NP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .win_req(win_req), .win_addr(win_addr), .win_ack(win_ack), .new_pixel(new_pixel),
    .compare_out(compare_out), .push_positions(push_positions), .iterated_idx(iterated_idx),
    .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_data(lbl_data)
  );

  always #5 clk = ~clk;

  int img [NP];
  int dr_t [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int dc_t [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int n_chk = 0, n_err = 0;
  int ack_delay = 0;
  int lbl_val [NP];
  int lbl_n [NP];
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nbr(int a, int k);
    int rr, cc;
    rr = a / N + dr_t[k];
    cc = a % N + dc_t[k];
    if (rr < 0 || rr >= M || cc < 0 || cc >= N) return -1;
    return rr * N + cc;
  endfunction

  function automatic logic is_max(int a);
    for (int k = 0; k < 8; k++)
      if (nbr(a, k) >= 0 && img[nbr(a, k)] > img[a]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] eq_mask(int a, logic [7:0] it);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 8; k++)
      if (nbr(a, k) >= 0 && img[nbr(a, k)] == img[a] && !it[k]) m[k] = 1'b1;
    return m;
  endfunction

  // Label / done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (lbl_we) begin
          lbl_val[lbl_addr] = int'(lbl_data);
          lbl_n[lbl_addr]++;
        end
        if (done) done_cnt++;
      end
    end
  end

  // Window comparator with programmable acknowledge latency
  initial begin
    int wait_cnt;
    logic ev;
    logic [AW-1:0] ev_addr, held;
    wait_cnt = 0; ev = 1'b0; ev_addr = '0; held = '0;
    forever begin
      @(posedge clk); #1;
      win_ack = 1'b0; compare_out = 1'b0; push_positions = '0;
      if (ev) begin
        push_positions = eq_mask(int'(ev_addr), iterated_idx);
        ev = 1'b0;
      end
      if (win_req) begin
        if (wait_cnt > 0) chk("win_addr_stable", 32'(win_addr), 32'(held));
        held = win_addr;
        if (wait_cnt >= ack_delay) begin
          win_ack = 1'b1;
          compare_out = is_max(int'(win_addr));
          ev = 1'b1;
          ev_addr = win_addr;
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  task automatic clear_lbl();
    for (int i = 0; i < NP; i++) begin lbl_val[i] = -1; lbl_n[i] = 0; end
    done_cnt = 0;
  endtask

  task automatic set_img(input int base);
    for (int i = 0; i < NP; i++) img[i] = base;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_img(input string tag, input int delay, input logic [15:0] exp, input bit restart);
    logic [15:0] got;
    int once, total;
    ack_delay = delay;
    clear_lbl();
    pulse_start();
    if (restart) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    got = '0; once = 0; total = 0;
    for (int i = 0; i < NP; i++) begin
      got[i] = (lbl_val[i] == 1);
      if (lbl_n[i] == 1) once++;
      total += lbl_n[i];
    end
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_labels"}, 32'(got), 32'(exp));
    chk({tag, "_each_once"}, 32'(once), 32'd16);
    chk({tag, "_total_writes"}, 32'(total), 32'd16);
  endtask

  initial begin
    bit found;
    int total;
    set_img(0);
    clear_lbl();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_win_req", 32'(win_req), 32'd0);
    chk("rst_new_pixel", 32'(new_pixel), 32'd0);
    chk("rst_lbl_we", 32'(lbl_we), 32'd0);
    reset_n = 1'b1;

    set_img(7);
    run_img("flat", 0, 16'hFFFF, 1'b0);

    set_img(0); img[5] = 9;
    run_img("peak5", 0, 16'h0020, 1'b0);

    set_img(0); img[0] = 5; img[1] = 5; img[2] = 6;
    run_img("plateau", 0, 16'h0004, 1'b0);
    run_img("plateau_slow", 3, 16'h0004, 1'b0);

    // Abandon a run while pushing neighbours of the first seed
    set_img(7);
    ack_delay = 0;
    clear_lbl();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (new_pixel) found = 1'b1;
    end
    chk("mid_reach_ack", 32'(found), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_win_req", 32'(win_req), 32'd0);
    chk("mid_new_pixel", 32'(new_pixel), 32'd0);
    chk("mid_lbl_we", 32'(lbl_we), 32'd0);
    repeat (5) @(posedge clk);
    total = 0;
    for (int i = 0; i < NP; i++) total += lbl_n[i];
    chk("mid_no_writes", 32'(total), 32'd0);
    run_img("post_rst", 0, 16'hFFFF, 1'b0);

    run_img("restart", 0, 16'hFFFF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/eda_region_ctrl.md
EDA_REGION_CTRL -- requirements
Module: eda_region_ctrl

Interface
REQ-001 Parameter M, default 16, image rows.
REQ-002 Parameter N, default 16, image columns.
REQ-003 Parameter ADDR_WIDTH, default $clog2(M*N), pixel address width; address = row*N + col.
REQ-004 Parameter FIFO_DEPTH, default M*N, internal address-queue depth.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a full-image labelling run.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse when every pixel is labelled.
REQ-010 win_req / win_addr  output  1 / ADDR_WIDTH  request for the 3x3 window centred on win_addr.
REQ-011 win_ack  input  1  window valid at the comparator this cycle; window is held stable until the next win_req.
REQ-012 new_pixel  output  1  comparator load strobe.
REQ-013 compare_out  input  1  1 = centre is not below any window value.
REQ-014 push_positions  input  8  equal-valued unprocessed neighbours, one-cycle valid.
REQ-015 iterated_idx  output  8  neighbours already processed in the current pass.
REQ-016 lbl_we / lbl_addr / lbl_data  output  1 / ADDR_WIDTH / 1  label write port; lbl_data 1 = regional maximum.

Function
REQ-017 Neighbour bit k SHALL map as: 0=NW, 1=N, 2=NE, 3=W, 4=E, 5=SW, 6=S, 7=SE (row/col offsets -1/0/+1).
REQ-018 The block SHALL keep a 2-bit state per pixel: 0 unvisited, 1 pass-1 visited, 2 labelled; all pixels SHALL be 0 on accepted start.
REQ-019 FSM states SHALL be IDLE, SCAN, P1_FETCH, P1_EVAL, P1_PUSH, P2_FETCH, P2_EVAL, P2_PUSH, DONE.
REQ-020 IDLE: start -> SCAN with scan pointer 0; start while busy SHALL be ignored.
REQ-021 SCAN: if state[ptr]==2, increment ptr (one cycle per pixel); else push ptr as seed, set state 1, set plateau_max=1, go to P1_FETCH; once ptr passes M*N-1, go to DONE.
REQ-022 P1_FETCH: pop queue head, assert win_req with win_addr=head until win_ack; in the ack cycle pulse new_pixel, sample compare_out and clear plateau_max if compare_out=0; go to P1_EVAL.
REQ-023 P1_EVAL (cycle after ack): sample push_positions masked by in-image neighbour validity into a pending mask; go to P1_PUSH.
REQ-024 P1_PUSH: push one pending neighbour per cycle, lowest bit first, set its state to 1 and clear its bit; when mask empty go to P1_FETCH if queue non-empty, else re-push seed, set seed state 2 and go to P2_FETCH.
REQ-025 iterated_idx bit k SHALL be 1 when neighbour k is out of image or has state >= the current pass number (1 in P1, 2 in P2).
REQ-026 P2_FETCH/P2_EVAL/P2_PUSH SHALL behave as P1 but push neighbours with state 1, set them to 2, and pulse lbl_we with lbl_addr=popped address, lbl_data=plateau_max in the win_ack cycle.
REQ-027 When P2 queue empties and mask is empty, increment scan pointer and return to SCAN.
REQ-028 DONE: pulse done for one cycle, clear busy, go to IDLE.
REQ-029 Queue SHALL be FIFO; with FIFO_DEPTH=M*N and each pixel pushed at most once per pass, overflow is unreachable; push into a full queue SHALL be dropped.
REQ-030 Every pixel SHALL receive exactly one lbl_we per run.

Reset
REQ-031 While reset_n=0 at a clock edge: FSM -> IDLE, busy=0, done=0, win_req=0, new_pixel=0, lbl_we=0, queue empty, pointers 0, all pixel states 0; a reset mid-run SHALL abandon the run with no further label writes.

Verification
REQ-032 M=N=4, all pixels 7, start -> 16 lbl_we with lbl_data=1, one done, busy low after.
REQ-033 4x4 zeros with pixel 5=9 -> pixel 5 labelled 1, other 15 labelled 0.
REQ-034 4x4, plateau {0,1} value 5 adjacent to pixel 2 value 6, rest 0 -> pixels 0,1 labelled 0, pixel 2 labelled 1.
REQ-035 win_ack delayed 3 cycles on every request -> win_req/win_addr stable until ack, labels identical to zero-delay run.
REQ-036 reset_n low for one cycle mid-P1_PUSH -> all outputs 0 next cycle; fresh start then completes with correct 16 labels.
REQ-037 start pulsed again while busy -> ignored; exactly one done per accepted start.
